reg_mask_encoder: RTL and testbench

- Inverse of the register-enable decoder.
- Accepts an 8-bit register mask, one bit per register r0..r7, for example a "registers to spill/dump" set from the control unit.
- Serially emits the 3-bit address of each set bit, lowest register first, over a valid/ready handshake.
- Sits between the control FSM and the register-file address mux; the downstream decoder turns each emitted address back into a one-hot enable.

---
 rtl/reg_mask_encoder.sv | 130 +++++++++++++
 tb/tb_reg_mask_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mask_encoder.sv
// Register mask encoder: serially emits the address of each set mask bit,
// lowest register first, over a valid/ready handshake.
module reg_mask_encoder #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                load,
  input  logic [NUM_REGS-1:0] mask_in,
  input  logic                abort,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                busy,
  output logic                done,
  output logic                empty,
  output logic [ADDR_W:0]     count
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nx;
  logic [NUM_REGS-1:0] cleared;
  logic [NUM_REGS-1:0] onehot;
  logic                valid_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic                busy_nx;
  logic                done_nx;
  logic                empty_nx;
  logic [ADDR_W:0]     count_nx;
  logic                fire;

  function automatic logic [ADDR_W-1:0] lsb_idx(
    input logic [NUM_REGS-1:0] m
  );
    lsb_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) lsb_idx = i[ADDR_W-1:0];
    end
  endfunction

  assign fire = out_valid & out_ready;

  always_comb begin
    onehot           = '0;
    onehot[out_addr] = 1'b1;
    cleared          = pending & ~onehot;
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    valid_nx   = out_valid;
    addr_nx    = out_addr;
    busy_nx    = busy;
    done_nx    = 1'b0;
    empty_nx   = 1'b0;
    count_nx   = count;
    unique case (state)
      IDLE: begin
        if (load) begin
          count_nx = '0;
          if (|mask_in) begin
            state_nx   = EMIT;
            pending_nx = mask_in;
            addr_nx    = lsb_idx(mask_in);
            valid_nx   = 1'b1;
            busy_nx    = 1'b1;
          end else begin
            done_nx  = 1'b1;
            empty_nx = 1'b1;
          end
        end
      end
      EMIT: begin
        if (fire) begin
          count_nx   = count + {{ADDR_W{1'b0}}, 1'b1};
          pending_nx = cleared;
        end
        // a handshake coinciding with abort still counts, but never signals done
        if (abort) begin
          state_nx   = IDLE;
          pending_nx = '0;
          valid_nx   = 1'b0;
          busy_nx    = 1'b0;
        end else if (fire) begin
          if (cleared == '0) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            addr_nx = lsb_idx(cleared);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      empty     <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      out_valid <= valid_nx;
      out_addr  <= addr_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      empty     <= empty_nx;
      count     <= count_nx;
    end
  end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Scoreboard bench for reg_mask_encoder: expected addresses are queued by
// the stimulus and popped by an independent monitor on every handshake.
module tb_reg_mask_encoder;

  logic       clock;
  logic       resetn;
  logic       load;
  logic [7:0] mask_in;
  logic       abort;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_addr;
  logic       busy;
  logic       done;
  logic       empty;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  bit hold;
  logic [2:0] hold_addr;
  int valid_seen;
  int done_cnt;

  reg_mask_encoder #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .load     (load),
    .mask_in  (mask_in),
    .abort    (abort),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .busy     (busy),
    .done     (done),
    .empty    (empty),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pop on handshake, check hold-stability while stalled
  always @(negedge clock) begin
    if (!resetn) begin
      hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (out_valid) valid_seen++;
      if (out_valid && hold) chk("stall_stable", out_addr, hold_addr);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_addr", out_addr, -1);
        end else begin
          chk("addr", out_addr, exp_q.pop_front());
        end
      end
      hold      = out_valid && !out_ready;
      hold_addr = out_addr;
    end
  end

  task automatic do_load(input logic [7:0] m);
    @(posedge clock);
    #1;
    load    = 1'b1;
    mask_in = m;
    @(posedge clock);
    #1;
    load    = 1'b0;
    mask_in = 8'h3C;
  endtask

  task automatic wait_done(input int budget, input bit toggle,
                           input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (toggle) begin
        @(posedge clock);
        #1;
        out_ready = ~out_ready;
      end
    end
    chk({name, "_done_seen"}, int'(got), 1);
  endtask

  int d0;

  initial begin
    resetn    = 1'b0;
    load      = 1'b0;
    mask_in   = 8'h00;
    abort     = 1'b0;
    out_ready = 1'b0;
    hold      = 1'b0;
    valid_seen = 0;
    done_cnt  = 0;
    #22;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_empty", empty, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", out_addr, 0);
    resetn = 1'b1;

    // mask 1010_0100, ready high
    out_ready = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(7);
    do_load(8'b1010_0100);
    @(negedge clock);
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_busy", busy, 1);
    wait_done(10, 1'b0, "t1");
    chk("t1_count", count, 3);
    chk("t1_busy_end", busy, 0);
    chk("t1_valid_end", out_valid, 0);
    chk("t1_q_empty", exp_q.size(), 0);
    @(negedge clock);
    chk("t1_done_pulse", done, 0);

    // full mask with toggling ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    d0 = done_cnt;
    do_load(8'hFF);
    wait_done(40, 1'b1, "t2");
    chk("t2_count", count, 8);
    chk("t2_q_empty", exp_q.size(), 0);
    @(negedge clock);
    chk("t2_single_done", done_cnt - d0, 1);

    // empty mask
    out_ready = 1'b1;
    valid_seen = 0;
    do_load(8'h00);
    @(negedge clock);
    chk("t3_empty", empty, 1);
    chk("t3_done", done, 1);
    chk("t3_count", count, 0);
    @(negedge clock);
    chk("t3_empty_pulse", empty, 0);
    chk("t3_done_pulse", done, 0);
    chk("t3_no_valid", valid_seen, 0);

    // abort together with first handshake
    out_ready = 1'b0;
    exp_q.push_back(0);
    d0 = done_cnt;
    do_load(8'h81);
    out_ready = 1'b1;
    abort     = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    @(negedge clock);
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_count", count, 1);
    repeat (4) @(negedge clock);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // load during EMIT is ignored
    out_ready = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(2);
    do_load(8'h06);
    load    = 1'b1;
    mask_in = 8'h10;
    @(posedge clock);
    #1;
    load      = 1'b0;
    out_ready = 1'b1;
    wait_done(10, 1'b0, "t5");
    chk("t5_count", count, 2);
    chk("t5_q_empty", exp_q.size(), 0);

    // async reset after 2 of 4 handshakes
    out_ready = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(3);
    do_load(8'h5A);
    @(posedge clock);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk("t6_count_pre", count, 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_count", count, 0);
    #3;
    resetn = 1'b1;
    exp_q.push_back(3);
    out_ready = 1'b1;
    do_load(8'h08);
    wait_done(10, 1'b0, "t6");
    chk("t6_count", count, 1);
    chk("t6_q_empty", exp_q.size(), 0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
